// File: rtl/port_ingress.sv
// Ingress stage of one switch port: a small packet FIFO whose head packet is
// offered to the output arbiters as a request mask. Multicast copies retire
// one grant at a time; the packet is popped once every target has taken it.
// Copies offered while the FIFO is full are rejected and counted.
module port_ingress #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NPORTS-1:0] target_in,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [NPORTS-1:0] req_out,
    output logic [DATA_W-1:0] head_data,
    input  logic [NPORTS-1:0] grant_in,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W:0]    CNT_ZERO  = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [NPORTS-1:0] MASK_ZERO = NPORTS'(1'b0);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(1'b0);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Number of output copies requested by a target mask.
    function automatic logic [CNT_W:0] popcount(input logic [NPORTS-1:0] mask);
        logic [CNT_W:0] ones;
        ones = (CNT_W+1)'(1'b0);
        for (int i = 0; i < NPORTS; i++) begin
            ones = ones + (CNT_W+1)'(mask[i]);
        end
        return ones;
    endfunction

    logic [DATA_W-1:0] mem_data_r [DEPTH];
    logic [NPORTS-1:0] mem_tgt_r  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              full_r;
    logic              empty_r;
    state_t            state_r;
    logic [NPORTS-1:0] pending_r;
    logic [DATA_W-1:0] head_data_r;
    logic [CNT_W-1:0]  drop_cnt_r;

    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic [NPORTS-1:0] pending_nxt_s;
    logic [PTR_W:0]    count_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_inc_s;
    logic [NPORTS-1:0] next_tgt_s;
    logic [DATA_W-1:0] next_data_s;
    logic [CNT_W:0]    drop_sum_s;

    // Decode push/pop/drop and pick the packet that becomes head after a pop.
    always_comb begin
        push_s        = valid_in & ~full_r & (target_in != MASK_ZERO);
        drop_s        = valid_in & full_r;
        pending_nxt_s = pending_r & ~grant_in;
        pop_s         = (state_r == SERVE) & (pending_nxt_s == MASK_ZERO);
        count_nxt_s   = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
        // With only the head stored, the next head can only be this cycle's arrival.
        if (count_r > CNT_ONE) begin
            next_tgt_s  = mem_tgt_r[rd_ptr_inc_s];
            next_data_s = mem_data_r[rd_ptr_inc_s];
        end else begin
            next_tgt_s  = target_in;
            next_data_s = data_in;
        end
        drop_sum_s = {1'b0, drop_cnt_r} + popcount(target_in);
    end

    // Packet storage; entries are written once and never modified in place.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= data_in;
            mem_tgt_r[wr_ptr_r]  <= target_in;
        end
    end

    // FIFO pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(1'b0);
            rd_ptr_r <= PTR_W'(1'b0);
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    // Saturating count of output copies rejected because storage was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            if (drop_sum_s[CNT_W]) begin
                drop_cnt_r <= CNT_SAT;
            end else begin
                drop_cnt_r <= drop_sum_s[CNT_W-1:0];
            end
        end
    end

    // Service FSM: loads the head request mask and retires copies on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= MASK_ZERO;
            head_data_r <= DATA_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_r != CNT_ZERO) begin
                        state_r     <= SERVE;
                        pending_r   <= mem_tgt_r[rd_ptr_r];
                        head_data_r <= mem_data_r[rd_ptr_r];
                    end else begin
                        pending_r   <= MASK_ZERO;
                        head_data_r <= DATA_ZERO;
                    end
                end
                SERVE: begin
                    if (!pop_s) begin
                        pending_r <= pending_nxt_s;
                    end else if (count_nxt_s != CNT_ZERO) begin
                        pending_r   <= next_tgt_s;
                        head_data_r <= next_data_s;
                    end else begin
                        state_r     <= IDLE;
                        pending_r   <= MASK_ZERO;
                        head_data_r <= DATA_ZERO;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pending_r   <= MASK_ZERO;
                    head_data_r <= DATA_ZERO;
                end
            endcase
        end
    end

    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;
    assign req_out    = pending_r;
    assign head_data  = head_data_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_port_ingress.sv
// Bench for port_ingress: directed scenarios followed by random traffic, all
// checked against a packet-queue reference model. A second instance with a
// 4-bit drop counter shares the stimulus to exercise counter saturation.
module tb_port_ingress;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] target_in = 4'h0;
    logic [3:0] grant_in = 4'h0;

    logic        fifo_full, fifo_empty;
    logic [3:0]  req_out;
    logic [7:0]  head_data;
    logic [15:0] drop_cnt;

    logic        full4, empty4;
    logic [3:0]  req4;
    logic [7:0]  head4;
    logic [3:0]  drop4;

    int checks = 0;
    int failures = 0;

    port_ingress #(.NPORTS(4), .DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .target_in(target_in), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .req_out(req_out), .head_data(head_data), .grant_in(grant_in),
        .drop_cnt(drop_cnt)
    );

    port_ingress #(.NPORTS(4), .DATA_W(8), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .target_in(target_in), .fifo_full(full4), .fifo_empty(empty4),
        .req_out(req4), .head_data(head4), .grant_in(grant_in),
        .drop_cnt(drop4)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] d;
        logic [3:0] t;
    } pkt_t;

    pkt_t       q[$];
    bit         m_serving;
    logic [3:0] m_pend;
    int         m_drop16;
    int         m_drop4;

    task automatic model_reset();
        q.delete();
        m_serving = 1'b0;
        m_pend    = 4'h0;
        m_drop16  = 0;
        m_drop4   = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d,
                              input logic [3:0] t, input logic [3:0] g);
        bit full;
        bit push;
        bit popped;
        logic [3:0] pn;
        pkt_t p;
        full   = (q.size() == 4);
        push   = v && !full && (t != 4'h0);
        popped = 1'b0;
        if (v && full) begin
            m_drop16 = m_drop16 + $countones(t);
            if (m_drop16 > 65535) m_drop16 = 65535;
            m_drop4 = m_drop4 + $countones(t);
            if (m_drop4 > 15) m_drop4 = 15;
        end
        if (m_serving) begin
            pn = m_pend & ~g;
            if (pn == 4'h0) begin
                void'(q.pop_front());
                popped = 1'b1;
            end else begin
                m_pend = pn;
            end
        end else if (q.size() != 0) begin
            m_serving = 1'b1;
            m_pend    = q[0].t;
        end
        if (push) begin
            p.d = d;
            p.t = t;
            q.push_back(p);
        end
        if (popped) begin
            if (q.size() > 0) begin
                m_pend = q[0].t;
            end else begin
                m_serving = 1'b0;
                m_pend    = 4'h0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [3:0] er;
        logic [7:0] eh;
        er = m_serving ? m_pend : 4'h0;
        eh = m_serving ? q[0].d : 8'h00;
        chk({tag, "_req"},   32'(req_out),    32'(er));
        chk({tag, "_head"},  32'(head_data),  32'(eh));
        chk({tag, "_full"},  32'(fifo_full),  32'(q.size() == 4));
        chk({tag, "_empty"}, 32'(fifo_empty), 32'(q.size() == 0));
        chk({tag, "_drop"},  32'(drop_cnt),   32'(m_drop16));
        chk({tag, "_drop4"}, 32'(drop4),      32'(m_drop4));
    endtask

    // One clock: drive at negedge, model the edge, check just after it.
    task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                         input logic [3:0] t, input logic [3:0] g);
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        target_in = t;
        grant_in  = g;
        @(posedge clk);
        model_edge(v, d, t, g);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        target_in = 4'h0;
        grant_in  = 4'h0;
        model_reset();
        #1;
        chk_all("reset");
        chk("reset_req", 32'(req_out), 32'h0);
        chk("reset_empty", 32'(fifo_empty), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // Reset state
        do_reset();

        // 1 Unicast
        cycle("t1_push", 1'b1, 8'hA5, 4'b0010, 4'b0000);
        cycle("t1_wait", 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("t1_req", 32'(req_out), 32'h2);
        chk("t1_head", 32'(head_data), 32'hA5);
        cycle("t1_grant", 1'b0, 8'h00, 4'b0000, 4'b0010);
        chk("t1_req_done", 32'(req_out), 32'h0);
        chk("t1_empty", 32'(fifo_empty), 32'h1);

        // 2 Multicast
        cycle("t2_push", 1'b1, 8'h3C, 4'b1011, 4'b0000);
        cycle("t2_wait", 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("t2_req0", 32'(req_out), 32'hB);
        cycle("t2_g1", 1'b0, 8'h00, 4'b0000, 4'b0001);
        chk("t2_req1", 32'(req_out), 32'hA);
        chk("t2_head1", 32'(head_data), 32'h3C);
        cycle("t2_g2", 1'b0, 8'h00, 4'b0000, 4'b1000);
        chk("t2_req2", 32'(req_out), 32'h2);
        chk("t2_head2", 32'(head_data), 32'h3C);
        cycle("t2_g3", 1'b0, 8'h00, 4'b0000, 4'b0010);
        chk("t2_req3", 32'(req_out), 32'h0);
        chk("t2_empty", 32'(fifo_empty), 32'h1);
        chk("t2_drop", 32'(drop_cnt), 32'h0);

        // 3 Overflow
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cycle("t3_push", 1'b1, 8'(i), 4'b0011, 4'b0000);
            if (i == 4) chk("t3_full4", 32'(fifo_full), 32'h1);
        end
        chk("t3_drop", 32'(drop_cnt), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_order", 32'(head_data), 32'(i));
            cycle("t3_grant", 1'b0, 8'h00, 4'b0000, 4'b0011);
        end
        chk("t3_empty", 32'(fifo_empty), 32'h1);

        // 4 Full + pop collision
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle("t4_fill", 1'b1, 8'h10 + 8'(i), 4'b0001 << i, 4'b0000);
        end
        chk("t4_full", 32'(fifo_full), 32'h1);
        chk("t4_req_head", 32'(req_out), 32'h1);
        cycle("t4_collide", 1'b1, 8'hEE, 4'b0111, 4'b0001);
        chk("t4_drop", 32'(drop_cnt), 32'h3);
        chk("t4_notfull", 32'(fifo_full), 32'h0);
        chk("t4_nobubble_req", 32'(req_out), 32'h2);
        chk("t4_nobubble_head", 32'(head_data), 32'h11);

        // 5 Noise
        do_reset();
        cycle("t5_null", 1'b1, 8'h77, 4'b0000, 4'b1111);
        chk("t5_null_empty", 32'(fifo_empty), 32'h1);
        cycle("t5_idle", 1'b0, 8'h00, 4'b0000, 4'b1111);
        chk("t5_idle_req", 32'(req_out), 32'h0);
        chk("t5_idle_drop", 32'(drop_cnt), 32'h0);
        cycle("t5_push", 1'b1, 8'h5A, 4'b0001, 4'b0000);
        cycle("t5_wait", 1'b0, 8'h00, 4'b0000, 4'b0000);
        cycle("t5_stray", 1'b0, 8'h00, 4'b0000, 4'b0100);
        chk("t5_stray_req", 32'(req_out), 32'h1);
        cycle("t5_grant", 1'b0, 8'h00, 4'b0000, 4'b0001);

        // 6 Reset mid-multicast, then counter saturation
        cycle("t6_push", 1'b1, 8'h3C, 4'b1011, 4'b0000);
        cycle("t6_wait", 1'b0, 8'h00, 4'b0000, 4'b0000);
        cycle("t6_g1", 1'b0, 8'h00, 4'b0000, 4'b0001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_req", 32'(req_out), 32'h0);
        chk("t6_async_empty", 32'(fifo_empty), 32'h1);
        chk_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("t6_fill", 1'b1, 8'(i), 4'b0001, 4'b0000);
        end
        for (int i = 0; i < 20; i++) begin
            cycle("t6_drop", 1'b1, 8'hFF, 4'b0100, 4'b0000);
        end
        chk("t6_sat4", 32'(drop4), 32'hF);
        chk("t6_cnt16", 32'(drop_cnt), 32'd20);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [7:0] d;
            logic [3:0] t;
            logic [3:0] g;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom_range(0, 255));
            t = 4'($urandom_range(0, 15));
            g = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cycle("rnd", v, d, t, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
